// File: rtl/cr_kme_fifo_beat_serializer.sv
// cr_kme_fifo_beat_serializer: pops 263-bit KME FIFO entries and serializes each 256-bit payload into 1..4 64-bit valid/ready beats carrying tag/eop.
//   Ports: clk, rst (sync, active-high); in_data/in_valid/in_ack = FIFO head + pop; out_data/out_tag/out_eop/out_last/out_valid/out_ready = beat bus;
//   beat_cnt = current beat index (debug). Macro KME_SER_PARITY_EN adds out_par (even parity over {out_tag, out_eop, out_data}).
module cr_kme_fifo_beat_serializer #(
  parameter int BEAT_W  = 64,
  parameter int ENTRY_W = 263
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ENTRY_W-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ack,
  output logic [BEAT_W-1:0]  out_data,
  output logic [3:0]         out_tag,
  output logic               out_eop,
  output logic               out_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         beat_cnt
`ifdef KME_SER_PARITY_EN
  ,
  output logic               out_par
`endif
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t       state_q, state_d;
  logic [255:0] pay_q, pay_d;
  logic [1:0]   nb_q, nb_d, cnt_q, cnt_d;
  logic [3:0]   tag_q, tag_d;
  logic         eop_q, eop_d;
  logic         hold_vld, acc;
  assign hold_vld = state_q == SEND;
  assign beat_cnt = cnt_q;
  always_comb begin
    out_valid = hold_vld;
    out_last  = hold_vld & (cnt_q == nb_q);
    out_eop   = out_last & eop_q;
    out_tag   = hold_vld ? tag_q : '0;
    out_data  = hold_vld ? pay_q[cnt_q*BEAT_W +: BEAT_W] : '0;
    acc       = out_valid & out_ready;
    // no pop while in reset, so the FIFO never loses an entry to a load that reset discards
    in_ack    = ~rst & in_valid & (~hold_vld | (acc & out_last));
    state_d   = state_q;
    pay_d     = pay_q;
    nb_d      = nb_q;
    tag_d     = tag_q;
    eop_d     = eop_q;
    cnt_d     = cnt_q;
    if (in_ack) begin
      state_d = SEND;
      pay_d   = in_data[255:0];
      nb_d    = in_data[257:256];
      eop_d   = in_data[258];
      tag_d   = in_data[262:259];
      cnt_d   = '0;
    end else if (acc) begin
      state_d = out_last ? IDLE : SEND;
      cnt_d   = out_last ? 2'd0 : cnt_q + 2'd1;
    end
  end
`ifdef KME_SER_PARITY_EN
  assign out_par = ^{out_tag, out_eop, out_data};
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pay_q   <= '0;
      nb_q    <= '0;
      tag_q   <= '0;
      eop_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pay_q   <= pay_d;
      nb_q    <= nb_d;
      tag_q   <= tag_d;
      eop_q   <= eop_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
